// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count_sched timer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_sched_pkg;

  // Number of requesters sharing the timer
  localparam int NREQ = 2;

  // Default timer / length width
  localparam int DEF_WIDTH = 4;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/count_sched_if.sv
// Requester-facing bundle of the timer scheduler: request levels and lengths in, grant/done/status out.
// Latency: n/a (wiring only).
// Backpressure: a requester holds req until it sees done or chooses to abandon.
interface count_sched_if
  import count_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [NREQ-1:0]  req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic             busy;
  logic [WIDTH-1:0] count;

  // Client side: drives requests and lengths, observes scheduler status
  modport master (
    output req, len0, len1,
    input  grant, done, busy, count
  );

  // Scheduler side
  modport slave (
    input  req, len0, len1,
    output grant, done, busy, count
  );

endinterface

// File: rtl/count_sched_rr_arb2.sv
// Two-input round-robin picker; holds the pointer to the last winner.
// Latency: grant_next is combinational from req; the pointer moves on the edge where advance is high.
// Backpressure: none; the caller decides when a pick is committed via advance.
module rr_arb2
  import count_sched_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant_next
);

  // 1 means requester 1 won last, so requester 0 takes the next tie
  logic last_q;

  // Single requester wins outright; a tie goes to whoever did not win last
  always_comb begin
    grant_next = '0;
    case (req)
      2'b01:   grant_next = 2'b01;
      2'b10:   grant_next = 2'b10;
      2'b11:   grant_next = last_q ? 2'b01 : 2'b10;
      default: grant_next = 2'b00;
    endcase
  end

  // Pointer follows the committed winner; an abandoned grant still counts as a win
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= grant_next[1];
    end
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler owning the shared down-counting delay timer for two requesters.
// Latency: done pulses L+2 edges after the request is sampled in IDLE; at least one IDLE cycle between grants.
// Backpressure: the non-owner's req is ignored while busy; owner dropping req abandons the run without done.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic         clk,
  input  logic         reset,
  count_sched_if.slave bus
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       state;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] len_q;

  logic [NREQ-1:0]  grant_next;
  logic             arb_advance;
  logic             owner_req;
  logic [WIDTH-1:0] win_len;

  // Commit a pick only when a grant is actually issued from IDLE
  assign arb_advance = (state == IDLE) && (|bus.req);

  // Owner still wants the timer; grant_q is one-hot so this selects its req bit
  assign owner_req = |(bus.req & grant_q);

  // Length of whoever is about to be granted
  assign win_len = grant_next[1] ? bus.len1 : bus.len0;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.req),
    .advance    (arb_advance),
    .grant_next (grant_next)
  );

  // Scheduler FSM with length latch and timer; abandon takes priority over counting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= '0;
          if (|bus.req) begin
            state   <= LOAD;
            grant_q <= grant_next;
            len_q   <= win_len;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (!owner_req) begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            count_q <= len_q;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!owner_req) begin
            // count is left frozen where the owner walked away
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (count_q == '0) begin
            state  <= DONE;
            done_q <= grant_q;
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: reset, single runs, zero length, tie alternation, abandon, async reset, len change, back-to-back.
module tb_count_sched;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  count_sched_if #(.WIDTH(4)) bus ();

  count_sched #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.req  = 2'b00;
    bus.len0 = 4'd0;
    bus.len1 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", bus.grant); end
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    reset = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    bus.req  = 2'b01;
    bus.len0 = 4'd3;
    bus.len1 = 4'd9;
    tick(); // e0
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL basic_grant_e0: got %b expected 01", bus.grant); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e0: got %b expected 1", bus.busy); end
    for (int k = 1; k <= 4; k++) begin
      tick(); // e1..e4: 3,2,1,0
      checks++; if (bus.count !== 4'(4 - k)) begin errors++; $display("FAIL basic_count_e%0d: got %0d expected %0d", k, bus.count, 4 - k); end
      checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL basic_early_done_e%0d: got %b expected 00", k, bus.done); end
    end
    tick(); // e5
    checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL basic_done_e5: got %b expected 01", bus.done); end
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL basic_grant_held_e5: got %b expected 01", bus.grant); end
    bus.req = 2'b00;
    tick(); // e6
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL basic_done_e6: got %b expected 00", bus.done); end
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL basic_grant_e6: got %b expected 00", bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_e6: got %b expected 0", bus.busy); end
  endtask

  task automatic test_zero_len();
    bus.req  = 2'b10;
    bus.len0 = 4'd7;
    bus.len1 = 4'd0;
    tick(); // e0
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL zero_grant_e0: got %b expected 10", bus.grant); end
    tick(); // e1
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL zero_count_e1: got %0d expected 0", bus.count); end
    tick(); // e2
    checks++; if (bus.done !== 2'b10) begin errors++; $display("FAIL zero_done_e2: got %b expected 10", bus.done); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL zero_count_e2: got %0d expected 0", bus.count); end
    bus.req = 2'b00;
    tick(); // e3
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL zero_nowrap_e3: got %0d expected 0", bus.count); end
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL zero_grant_e3: got %b expected 00", bus.grant); end
  endtask

  task automatic test_tie();
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    bus.req  = 2'b11;
    bus.len0 = 4'd1;
    bus.len1 = 4'd2;
    tick(); // e0
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL tie_first_grant: got %b expected 01", bus.grant); end
    tick(); tick(); tick(); // e3
    checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL tie_done0_e3: got %b expected 01", bus.done); end
    bus.req = 2'b10;
    tick(); // e4 back to IDLE
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL tie_idle_e4: got %b expected 00", bus.grant); end
    tick(); // e5
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL tie_second_grant_e5: got %b expected 10", bus.grant); end
    tick(); // e6
    checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL tie_count1_e6: got %0d expected 2", bus.count); end
    tick(); tick(); tick(); // e9
    checks++; if (bus.done !== 2'b10) begin errors++; $display("FAIL tie_done1_e9: got %b expected 10", bus.done); end
    bus.req = 2'b11;
    tick(); // e10
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL tie_idle_e10: got %b expected 00", bus.grant); end
    tick(); // e11
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL tie_alternate_e11: got %b expected 01", bus.grant); end
    bus.req = 2'b00;
    tick(); // abandon from LOAD
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tie_abandon_load_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL tie_abandon_load_done: got %b expected 00", bus.done); end
  endtask

  task automatic test_abandon();
    bus.req  = 2'b01;
    bus.len0 = 4'd5;
    bus.len1 = 4'd0;
    tick(); // e0
    for (int k = 1; k <= 4; k++) begin
      tick(); // 5,4,3,2
      checks++; if (bus.count !== 4'(6 - k)) begin errors++; $display("FAIL abandon_count_e%0d: got %0d expected %0d", k, bus.count, 6 - k); end
    end
    bus.req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL abandon_grant_%0d: got %b expected 00", k, bus.grant); end
      checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL abandon_done_%0d: got %b expected 00", k, bus.done); end
      checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL abandon_count_hold_%0d: got %0d expected 2", k, bus.count); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abandon_busy_%0d: got %b expected 0", k, bus.busy); end
    end
  endtask

  task automatic test_reset_mid();
    // requester 0 wins here, so without a pointer reset a tie would go to requester 1
    bus.req  = 2'b01;
    bus.len0 = 4'd6;
    tick(); tick(); tick(); tick(); // e3
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL rstmid_count_e3: got %0d expected 4", bus.count); end
    reset = 1'b0;
    #1;
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant: got %b expected 00", bus.grant); end
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL rstmid_done: got %b expected 00", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", bus.count); end
    bus.req  = 2'b11;
    bus.len0 = 4'd2;
    bus.len1 = 4'd2;
    tick();
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rstmid_held_grant: got %b expected 00", bus.grant); end
    reset = 1'b1;
    tick();
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL rstmid_tie_after_reset: got %b expected 01", bus.grant); end
    bus.req = 2'b00;
    tick();
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rstmid_abandon_grant: got %b expected 00", bus.grant); end
  endtask

  task automatic test_len_change();
    bus.req  = 2'b01;
    bus.len0 = 4'd6;
    tick(); // e0
    tick(); // e1
    checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL lenchg_count_e1: got %0d expected 6", bus.count); end
    bus.len0 = 4'd1;
    for (int k = 2; k <= 7; k++) begin
      tick(); // 5..0
      checks++; if (bus.count !== 4'(7 - k)) begin errors++; $display("FAIL lenchg_count_e%0d: got %0d expected %0d", k, bus.count, 7 - k); end
      checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL lenchg_early_done_e%0d: got %b expected 00", k, bus.done); end
    end
    tick(); // e8
    checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL lenchg_done_e8: got %b expected 01", bus.done); end
    // req held: next grant lands at e(L+4) = e10
    tick(); // e9
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL lenchg_idle_e9: got %b expected 00", bus.grant); end
    tick(); // e10
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL lenchg_regrant_e10: got %b expected 01", bus.grant); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.req  = 2'b10;
    bus.len1 = 4'd0;
    tick(); // e0
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL b2b_grant_e0: got %b expected 10", bus.grant); end
    tick(); tick(); // e2
    checks++; if (bus.done !== 2'b10) begin errors++; $display("FAIL b2b_done_e2: got %b expected 10", bus.done); end
    tick(); // e3
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL b2b_idle_e3: got %b expected 00", bus.grant); end
    checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL b2b_done_e3: got %b expected 00", bus.done); end
    tick(); // e4
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL b2b_regrant_e4: got %b expected 10", bus.grant); end
    bus.req = 2'b00;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_final_busy: got %b expected 0", bus.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_tie();
    test_abandon();
    test_reset_mid();
    test_len_change();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
